life_gen_engine: RTL and testbench

//  Computes one Game-of-Life generation (B3/S23) over an X-by-Y grid supplied as a raster-order

---
 rtl/life_gen_engine_pkg.sv | 15 +
 rtl/life_gen_engine_rule.sv | 21 ++
 rtl/life_gen_engine.sv | 130 +++++++++++++
 tb/tb_life_gen_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/life_gen_engine_pkg.sv
// Shared rule constants and FSM encoding for the serial Game-of-Life engine.
// Latency/backpressure: not applicable (declarations only).
package life_gen_engine_pkg;

  localparam int LIFE_BIRTH = 3;
  localparam int LIFE_SURV  = 2;
  localparam int NBR_W      = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/life_gen_engine_rule.sv
// B3/S23 rule on a masked 3x3 window (bit 4 = centre), purely combinational.
// Latency 0; no flow control.
module life_rule
  import life_gen_engine_pkg::*;
(
  input  logic [8:0] win_i,
  output logic       next_o
);

  logic [NBR_W-1:0] nbr_cnt;

  always_comb begin
    nbr_cnt = '0;
    for (int k = 0; k < 9; k++) begin
      if (k != 4) nbr_cnt = nbr_cnt + NBR_W'(win_i[k]);
    end
    next_o = (nbr_cnt == NBR_W'(LIFE_BIRTH)) |
             (win_i[4] & (nbr_cnt == NBR_W'(LIFE_SURV)));
  end

endmodule

// File: rtl/life_gen_engine.sv
// One Game-of-Life generation over a raster-order bitstream; 1 clock from advance to output.
// Input stalls only during the X+1-cycle end-of-frame flush; output has no backpressure.
module life_gen_engine
  import life_gen_engine_pkg::*;
#(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_data,
  output logic out_valid,
  output logic out_data,
  output logic out_last
);

  localparam int CW = LOG2X + LOG2Y;
  localparam int HW = 2 * X + 2;
  localparam logic [LOG2X-1:0] COL_LAST  = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] ROW_LAST  = LOG2Y'(Y - 1);
  localparam logic [CW-1:0]    FILL_LAST = CW'(X);
  localparam logic [CW-1:0]    RUN_LAST  = CW'(X * Y - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LOG2X-1:0] ccol_q, ccol_d;
  logic [LOG2Y-1:0] crow_q, crow_d;
  logic [HW-1:0]    hist_q, hist_d;
  logic             out_valid_q, out_data_q, out_last_q;

  logic          adv, emit, new_bit, frame_end, nxt;
  logic [HW:0]   w;
  logic [8:0]    win;
  logic          top_ok, bot_ok, lft_ok, rgt_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (adv && cnt_q == FILL_LAST) state_d = RUN;
      RUN:     if (adv && cnt_q == RUN_LAST)  state_d = FLUSH;
      FLUSH:   if (frame_end)                 state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Flush steps advance unconditionally, feeding zeros behind the last row.
  always_comb begin
    in_ready = (state_q != FLUSH);
    adv      = in_ready ? in_valid : 1'b1;
    emit     = adv & (state_q != FILL);
    new_bit  = (state_q == FLUSH) ? 1'b0 : in_data;
  end

  // The full 2X+3-bit neighbourhood span is the stored history plus the incoming bit.
  assign w         = {hist_q, new_bit};
  assign frame_end = emit & (crow_q == ROW_LAST) & (ccol_q == COL_LAST);

  assign top_ok = (crow_q != '0);
  assign bot_ok = (crow_q != ROW_LAST);
  assign lft_ok = (ccol_q != '0);
  assign rgt_ok = (ccol_q != COL_LAST);

  always_comb begin
    win[0] = w[2*X+2] & top_ok & lft_ok;
    win[1] = w[2*X+1] & top_ok;
    win[2] = w[2*X]   & top_ok & rgt_ok;
    win[3] = w[X+2]   & lft_ok;
    win[4] = w[X+1];
    win[5] = w[X]     & rgt_ok;
    win[6] = w[2]     & bot_ok & lft_ok;
    win[7] = w[1]     & bot_ok;
    win[8] = w[0]     & bot_ok & rgt_ok;
  end

  life_rule u_rule (
    .win_i  (win),
    .next_o (nxt)
  );

  always_comb begin
    hist_d = adv ? w[HW-1:0] : hist_q;
    cnt_d  = cnt_q;
    if (state_q == FLUSH) cnt_d = '0;
    else if (adv)         cnt_d = cnt_q + 1'b1;
    ccol_d = ccol_q;
    crow_d = crow_q;
    if (emit) begin
      if (ccol_q == COL_LAST) begin
        ccol_d = '0;
        crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + 1'b1;
      end else begin
        ccol_d = ccol_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      hist_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ccol_q      <= ccol_d;
      crow_q      <= crow_d;
      hist_q      <= hist_d;
      out_valid_q <= emit;
      out_data_q  <= emit & nxt;
      out_last_q  <= frame_end;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine on an 8x8 grid; expected frames are hand-computed constants.
module tb_life_gen_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_data = 1'b0;
  logic in_ready, out_valid, out_data, out_last;

  always #5 clk = ~clk;

  life_gen_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  int checks = 0;
  int errors = 0;

  logic got_d [0:511];
  logic got_l [0:511];
  int   out_cnt  = 0;
  int   bad_lat  = 0;
  int   ready_lo = 0;
  logic adv_prev = 1'b0;

  // Output recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (out_cnt < 512) begin
        got_d[out_cnt] = out_data;
        got_l[out_cnt] = out_last;
      end
      out_cnt++;
      if (!adv_prev) bad_lat++;
    end
    if (!in_ready) ready_lo++;
    adv_prev = reset & (in_ready ? in_valid : 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [63:0] f, input bit toggle, input int n);
    int   i   = 0;
    int   cyc = 0;
    bit   ph  = 1'b1;
    logic acc;
    while (i < n && cyc < 2000) begin
      in_valid = toggle ? ph : 1'b1;
      ph       = ~ph;
      in_data  = f[i];
      acc      = in_valid & in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    in_data  = 1'b0;
    chk("accepts", 64'(i), 64'(n));
  endtask

  task automatic wait_outputs(input int target);
    int cyc = 0;
    while (out_cnt < target && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("out_count", 64'(out_cnt), 64'(target));
  endtask

  function automatic logic [63:0] frame_data(input int base);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[k] = got_d[base+k];
    return v;
  endfunction

  function automatic logic [63:0] frame_last(input int base);
    logic [63:0] v;
    for (int k = 0; k < 64; k++) v[k] = got_l[base+k];
    return v;
  endfunction

  logic [63:0] blink_in, blink_out, block_v, nowrap_in, ones_v, corners_v, last_only;
  int base, rl, lat0;

  initial begin
    blink_in  = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    blink_out = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    block_v   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    nowrap_in = (64'd1 << 30) | (64'd1 << 31) | (64'd1 << 32);
    ones_v    = '1;
    corners_v = (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63);
    last_only = 64'd1 << 63;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Blinker, in_valid held high
    base = out_cnt; rl = ready_lo;
    send_frame(blink_in, 1'b0, 64);
    wait_outputs(base + 64);
    chk("blinker_data", frame_data(base), blink_out);
    chk("blinker_last", frame_last(base), last_only);
    chk("blinker_ready_low", 64'(ready_lo - rl), 64'd9);

    // Block in the top-left corner
    base = out_cnt;
    send_frame(block_v, 1'b0, 64);
    wait_outputs(base + 64);
    chk("block_data", frame_data(base), block_v);
    chk("block_last", frame_last(base), last_only);

    // Row-end neighbours must not wrap
    base = out_cnt;
    send_frame(nowrap_in, 1'b0, 64);
    wait_outputs(base + 64);
    chk("nowrap_data", frame_data(base), 64'd0);

    // Back-to-back: all ones then all zeros
    base = out_cnt; rl = ready_lo;
    send_frame(ones_v, 1'b0, 64);
    send_frame(64'd0, 1'b0, 64);
    wait_outputs(base + 128);
    chk("ones_data",  frame_data(base),      corners_v);
    chk("ones_last",  frame_last(base),      last_only);
    chk("zeros_data", frame_data(base + 64), 64'd0);
    chk("zeros_last", frame_last(base + 64), last_only);
    chk("b2b_ready_low", 64'(ready_lo - rl), 64'd18);

    // Blinker with in_valid toggling
    base = out_cnt; lat0 = bad_lat;
    send_frame(blink_in, 1'b1, 64);
    wait_outputs(base + 64);
    chk("toggle_data", frame_data(base), blink_out);
    chk("toggle_last", frame_last(base), last_only);
    chk("toggle_latency", 64'(bad_lat - lat0), 64'd0);

    // Reset after 20 accepts, then replay blinker
    base = out_cnt;
    send_frame(blink_in, 1'b0, 20);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data",  64'(out_data),  64'd0);
    chk("midrst_out_last",  64'(out_last),  64'd0);
    chk("midrst_state", 64'(dut.state_q), 64'(life_gen_engine_pkg::FILL));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    begin
      int lasts = 0;
      for (int k = base; k < out_cnt; k++) if (got_l[k] === 1'b1) lasts++;
      chk("midrst_no_last", 64'(lasts), 64'd0);
    end
    base = out_cnt;
    send_frame(blink_in, 1'b0, 64);
    wait_outputs(base + 64);
    chk("replay_data", frame_data(base), blink_out);
    chk("replay_last", frame_last(base), last_only);
    chk("total_latency", 64'(bad_lat), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
